scan_seq: RTL
=============

SCAN_SEQ -- requirements
Module: scan_seq

Interface
REQ-001 SHALL provide parameter: DIV, 4, clocks per index step; legal range 2..256.
REQ-002 SHALL provide parameter: LAST, 7, highest index visited; legal range 1..7; scan range is 0..LAST.
REQ-003 SHALL provide port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL provide port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port: run  input  1  level; 1 = scan, 0 = idle.
REQ-006 SHALL provide port: dir  input  1  step direction; 0 = up, 1 = down; sampled only at a step.
REQ-007 SHALL provide port: clear  input  1  synchronous; forces index and prescaler to 0.
REQ-008 SHALL provide port: idx  output  3  current select index; drives a 3-to-8 decoder select input.
REQ-009 SHALL provide port: en  output  1  decoder enable.
REQ-010 SHALL provide port: step  output  1  one-clock pulse in the cycle idx first shows a new value.
REQ-011 SHALL provide port: wrap  output  1  one-clock pulse coincident with step when idx wraps.

Function
REQ-012 SHALL register all outputs; no combinational path from any input to any output.
REQ-013 SHALL implement two states: IDLE and SCAN.
REQ-014 IDLE -> SCAN at the first edge with run=1; prescaler cleared to 0 on entry; idx retained.
REQ-015 SCAN -> IDLE at the first edge with run=0; prescaler cleared; idx retained; step and wrap 0.
REQ-016 In SCAN, the prescaler SHALL count 0..DIV-1 and increment every clock.
REQ-017 On the edge where prescaler = DIV-1: prescaler goes to 0, idx steps, and step = 1 for exactly that following cycle.
REQ-018 Up step: idx = (idx = LAST) ? 0 : idx+1. Down step: idx = (idx = 0) ? LAST : idx-1.
REQ-019 wrap SHALL be 1 with step only on LAST->0 (up) or 0->LAST (down).
REQ-020 idx > LAST (only possible if LAST is reparameterised) is undefined usage; the block need not recover from it.
REQ-021 Steady step period in SCAN SHALL be exactly DIV clocks.
REQ-022 en = 1 in SCAN and 0 in IDLE (subject to REQ-028).
REQ-023 clear = 1 SHALL set idx = 0 and prescaler = 0 at that edge in any state, with priority over a step; step and wrap are 0 for that cycle; state is unaffected.
REQ-024 A dir change between steps SHALL take effect only at the next step; it causes no extra step.
REQ-025 If run falls on the same edge a step would occur, the IDLE transition wins: no step, idx unchanged.

Reset
REQ-026 rst_n = 0 SHALL immediately force: state IDLE, prescaler 0, idx 0, en 0, step 0, wrap 0.
REQ-027 Reset asserted mid-scan SHALL abort with no partial step; after release, the block stays in IDLE until run = 1 is sampled.

Configuration
REQ-028 Macro SCAN_BLANK_EN defined: en SHALL be 0 in every cycle where step = 1, giving one blanking clock per index change (anti-ghosting); otherwise en follows REQ-022.
REQ-029 Macro SCAN_BLANK_EN undefined: en follows REQ-022 exactly; no blanking; idx, step and wrap timing are identical in both builds.

Verification (DIV=4, LAST=7)
REQ-030 Reset then run=1, dir=0 -> idx sequence 0,1,...,7,0 with each value held 4 clocks; step every 4th clock; wrap only on the 7->0 transition.
REQ-031 Running with idx=2, dir=1 -> idx goes 1, then 0, then 7 with wrap=1, then 6.
REQ-032 clear=1 while idx=5 and prescaler=3 -> next cycle idx=0, step=0; the next step occurs 4 clocks later to idx=1.
REQ-033 run falls at the edge where prescaler=3 with idx=4 -> IDLE, en=0, idx stays 4, no step; run=1 again -> first step 4 clocks later to idx=5.
REQ-034 rst_n pulled low asynchronously mid-scan with idx=6 -> outputs are 0 and idx=0 before the next clk edge.
REQ-035 SCAN_BLANK_EN defined, steady scan -> en pattern 0,1,1,1 repeating, aligned with step=1; undefined -> en constantly 1.

Source files
------------

// File: rtl/scan_seq.sv
// -----------------------------------------------------------------------------
// scan_seq -- prescaled index scanner for a 3-to-8 select decoder.
//
// While run is high the block walks idx through 0..LAST (up or down, chosen by
// dir at each step), holding every value for DIV clocks. step pulses for one
// clock in the cycle idx first shows a new value; wrap pulses together with step
// when idx rolls over (LAST->0 going up, 0->LAST going down). clear
// synchronously returns idx and the prescaler to 0 without touching the state.
//
// Parameters
//   DIV   clocks per index step, 2..256
//   LAST  highest index visited, 1..7
//
// Ports
//   clk    in   single clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   run    in   level: 1 = scan, 0 = idle
//   dir    in   step direction, 0 = up, 1 = down, sampled only at a step
//   clear  in   synchronous: idx and prescaler to 0, overrides a step
//   idx    out  current select index (registered)
//   en     out  decoder enable (registered)
//   step   out  one-clock pulse on index change (registered)
//   wrap   out  one-clock pulse with step on roll-over (registered)
//
// Build option
//   SCAN_BLANK_EN  when defined, en is dropped in every cycle where step = 1,
//                  blanking the decoder for one clock per index change.
//                  idx, step and wrap timing are the same in both builds.
// -----------------------------------------------------------------------------
module scan_seq #(
    parameter int unsigned DIV  = 4,
    parameter int unsigned LAST = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       dir,
    input  logic       clear,
    output logic [2:0] idx,
    output logic       en,
    output logic       step,
    output logic       wrap
);

    // DIV >= 2, so the prescaler is always at least one bit wide.
    localparam int unsigned PW = $clog2(DIV);

    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(LAST);

`ifdef SCAN_BLANK_EN
    localparam logic BLANK_EN = 1'b1;
`else
    localparam logic BLANK_EN = 1'b0;
`endif

    typedef enum logic [0:0] {
        StIdle,
        StScan
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic          step_q, step_d;
    logic          wrap_q, wrap_d;
    logic          en_q, en_d;

    // Candidate next indices and their roll-over flags.
    logic [2:0] idx_up, idx_dn;
    logic       wrap_up, wrap_dn;

    always_comb begin
        wrap_up = (idx_q == IDX_LAST);
        wrap_dn = (idx_q == 3'd0);
        idx_up  = wrap_up ? 3'd0 : idx_q + 3'd1;
        idx_dn  = wrap_dn ? IDX_LAST : idx_q - 3'd1;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        idx_d   = idx_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (run) begin
                    state_d = StScan;
                    presc_d = '0;
                end
            end
            StScan: begin
                // Dropping run beats a step due on the same edge.
                if (!run) begin
                    state_d = StIdle;
                    presc_d = '0;
                end else if (presc_q == PRESC_MAX) begin
                    presc_d = '0;
                    step_d  = 1'b1;
                    idx_d   = dir ? idx_dn : idx_up;
                    wrap_d  = dir ? wrap_dn : wrap_up;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
        endcase

        // clear overrides any step but leaves the state transition alone.
        if (clear) begin
            idx_d   = 3'd0;
            presc_d = '0;
            step_d  = 1'b0;
            wrap_d  = 1'b0;
        end

        // en is computed from next state so it is registered alongside idx.
        en_d = (state_d == StScan) && !(BLANK_EN && step_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            presc_q <= '0;
            idx_q   <= 3'd0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
            en_q    <= en_d;
        end
    end

    assign idx  = idx_q;
    assign en   = en_q;
    assign step = step_q;
    assign wrap = wrap_q;

endmodule
